serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 157 +++++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one 1-bit full-adder cell.
// Operands are captured on an accepted start. One bit is processed per clock, LSB first.
// The finished sum and carry are published on the final BUSY edge, together with a one-cycle done pulse.

// FullAdderCell: combinational 1-bit full adder (sum = a^b^c, carry = majority).
module FullAdderCell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  // Pure combinational cell; the sequencer around it supplies the carry flop.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (a & c) | (b & c);
  end

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } StateT;

  StateT state;
  StateT stateNext;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             sum;
  logic             carry;
  logic [WIDTH-1:0] sNext;
  logic             lastBit;
  logic             accept;

  // The single full-adder cell is always fed by the current LSBs and the carry flop.
  FullAdderCell u_fa (
    .a    (a[0]),
    .b    (b[0]),
    .c    (c),
    .sum  (sum),
    .carry(carry)
  );

  // Decode handshake conditions and the next partial-result word.
  // The shift-then-insert form also works for WIDTH=1, where s[WIDTH-1:1] would be an empty slice.
  always_comb begin
    lastBit          = (cnt == CW'(WIDTH - 1));
    accept           = start && ((state == IDLE) || (state == DONE));
    sNext            = s >> 1;
    sNext[WIDTH-1]   = sum;
  end

  // State register; reset wins over everything, which aborts any addition in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. DONE with start held high goes straight back to BUSY, so there is no idle gap.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (lastBit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (start) begin
          stateNext = BUSY;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, then shift one bit per BUSY cycle.
  // out/carryOut are written only on the final bit, so partial sums are never visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      a        <= '0;
      b        <= '0;
      s        <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      out      <= '0;
      carryOut <= 1'b0;
    end else if (accept) begin
      a   <= inA;
      b   <= inB;
      c   <= carryIn;
      s   <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      a   <= a >> 1;
      b   <= b >> 1;
      c   <= carry;
      s   <= sNext;
      cnt <= cnt + CW'(1);
      if (lastBit) begin
        out      <= sNext;
        carryOut <= carry;
      end
    end
  end

  // Status flags come straight from the state register, so they are glitch-free and mutually exclusive.
  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  // The bit counter must never run past the last bit while an addition is in flight.
  assert property (@(posedge clock) disable iff (reset)
                   (state == BUSY) |-> (cnt <= CW'(WIDTH - 1)));

  // busy and done must never be high in the same cycle.
  assert property (@(posedge clock) disable iff (reset) !(busy && done));

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector bench for serial_adder with WIDTH=8.
module tb_serial_adder;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       carryIn;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       carryOut;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .carryIn (carryIn),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .carryOut(carryOut)
  );

  // 10-time-unit clock; the bench drives and samples on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something wedges despite the bounded loops.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one addition. Operands are scrambled right after acceptance.
  // The task returns at the negedge where done is seen, or when the bound runs out.
  // lat counts negedges after the accepting edge.
  task automatic runOp(input logic [7:0] opA, input logic [7:0] opB, input logic opC,
                       output int lat);
    @(negedge clock);
    start = 1'b1; inA = opA; inB = opB; carryIn = opC;
    @(negedge clock);
    start = 1'b0; inA = ~opA; inB = ~opB; carryIn = ~opC;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Reset for two cycles, then confirm a quiet idle state.
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inA = 8'h00; inB = 8'h00; carryIn = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++;
      if (out !== 8'h00) begin errors++; $display("[TB] FAIL reset_out got %h want 00", out); end
      checks++;
      if (carryOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got %b want 0", carryOut); end
    end
  endtask

  // 0x3C+0x42: busy for 8 cycles, done on the 9th, result held afterwards.
  task automatic test_basic();
    @(negedge clock);
    start = 1'b1; inA = 8'h3C; inB = 8'h42; carryIn = 1'b0;
    @(negedge clock);
    start = 1'b0; inA = 8'hFF; inB = 8'hFF; carryIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy cycle %0d got %b want 1", i, busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_done cycle %0d got %b want 0", i, done); end
      checks++;
      if (out !== 8'h00) begin errors++; $display("[TB] FAIL basic_partial cycle %0d got %h want 00", i, out); end
      @(negedge clock);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done got %b want 1", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end got %b want 0", busy); end
    checks++;
    if (out !== 8'h7E) begin errors++; $display("[TB] FAIL basic_out got %h want 7e", out); end
    checks++;
    if (carryOut !== 1'b0) begin errors++; $display("[TB] FAIL basic_cout got %b want 0", carryOut); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL basic_idle_flags got busy=%b done=%b want 0/0", busy, done);
      end
      checks++;
      if (out !== 8'h7E || carryOut !== 1'b0) begin
        errors++; $display("[TB] FAIL basic_hold got %b/%h want 0/7e", carryOut, out);
      end
    end
  endtask

  // Carry-out cases: 0xFF+0x01 and 0xA5+0x5A+1.
  task automatic test_overflow();
    int lat;
    runOp(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("[TB] FAIL ovf1_latency got %0d want 9", lat); end
    checks++;
    if (out !== 8'h00 || carryOut !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf1_result got %b/%h want 1/00", carryOut, out);
    end
    runOp(8'hA5, 8'h5A, 1'b1, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("[TB] FAIL ovf2_latency got %0d want 9", lat); end
    checks++;
    if (out !== 8'h00 || carryOut !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf2_result got %b/%h want 1/00", carryOut, out);
    end
  endtask

  // A start pulse during BUSY must be ignored; there is exactly one done pulse.
  task automatic test_start_ignored();
    int lat = 0;
    int doneCount = 0;
    int doneAt = 0;
    logic [7:0] outAtDone = 8'h00;
    logic coutAtDone = 1'b0;
    @(negedge clock);
    start = 1'b1; inA = 8'h3C; inB = 8'h42; carryIn = 1'b0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin
          doneAt = lat; outAtDone = out; coutAtDone = carryOut;
        end
      end
      if (lat == 1) begin start = 1'b0; inA = 8'h00; inB = 8'h00; end
      if (lat == 3) begin start = 1'b1; inA = 8'h11; inB = 8'h11; end
      if (lat == 4) begin start = 1'b0; end
    end
    checks++;
    if (doneCount !== 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d want 1", doneCount); end
    checks++;
    if (doneAt !== 9) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 9", doneAt); end
    checks++;
    if (outAtDone !== 8'h7E || coutAtDone !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_result got %b/%h want 0/7e", coutAtDone, outAtDone);
    end
  endtask

  // Start held high: operands change in the DONE cycle, and done pulses come 9 cycles apart.
  task automatic test_back_to_back();
    int lat = 0;
    int doneCount = 0;
    int firstAt = 0;
    int secondAt = 0;
    @(negedge clock);
    start = 1'b1; inA = 8'h01; inB = 8'h02; carryIn = 1'b0;
    while (lat < 30) begin
      @(negedge clock);
      lat++;
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin
          firstAt = lat;
          checks++;
          if (out !== 8'h03 || carryOut !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_first got %b/%h want 0/03", carryOut, out);
          end
          inA = 8'h80; inB = 8'h80;
        end else if (doneCount == 2) begin
          secondAt = lat;
          checks++;
          if (out !== 8'h00 || carryOut !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_second got %b/%h want 1/00", carryOut, out);
          end
          start = 1'b0;
        end
      end
    end
    checks++;
    if (doneCount !== 2) begin errors++; $display("[TB] FAIL b2b_done_count got %0d want 2", doneCount); end
    checks++;
    if (firstAt !== 9) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 9", firstAt); end
    checks++;
    if (secondAt - firstAt !== 9) begin
      errors++; $display("[TB] FAIL b2b_spacing got %0d want 9", secondAt - firstAt);
    end
  endtask

  // Reset mid-addition aborts it; a fresh addition afterwards still works.
  task automatic test_reset_abort();
    int lat;
    int strayDone = 0;
    @(negedge clock);
    start = 1'b1; inA = 8'h3C; inB = 8'h42; carryIn = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_flags got busy=%b done=%b want 0/0", busy, done);
    end
    checks++;
    if (out !== 8'h00 || carryOut !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_result got %b/%h want 0/00", carryOut, out);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) strayDone++;
    end
    checks++;
    if (strayDone !== 0) begin errors++; $display("[TB] FAIL abort_stray got %0d want 0", strayDone); end
    runOp(8'h10, 8'h20, 1'b1, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("[TB] FAIL fresh_latency got %0d want 9", lat); end
    checks++;
    if (out !== 8'h31 || carryOut !== 1'b0) begin
      errors++; $display("[TB] FAIL fresh_result got %b/%h want 0/31", carryOut, out);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
